fuzzify_ec_2: RTL and testbench
===============================

# fuzzify_ec_2

Upstream fuzzifier for the phase-2 fuzzy controller. It accepts a stream of signed error samples e(k), forms the error change EC = e(k) − e(k−1), scales and quantises EC onto the 17-level universe 0..16 (8 = ZE), and delivers the 5-bit index as `fuzzy_EC` to the inference stage. It is a two-stage registered pipeline with valid/ready handshakes on both sides, a priming state for the first sample, and saturation reporting.

## Interface

Parameters:
- `DATA_W`, 16 — width of the signed error sample.
- `QUANT_SHIFT`, 4 — EC scale factor; quantum = 2^QUANT_SHIFT LSBs per fuzzy level.

Ports:
- `clk` in 1 — single clock; everything is on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `clr` in 1 — synchronous re-prime; discards the stored previous sample.
- `err_valid` in 1 — `err_in` is valid.
- `err_in` in DATA_W — signed two's-complement error sample e(k).
- `err_ready` out 1 — the block accepts a sample this cycle.
- `ec_valid` out 1 — `fuzzy_EC` and `ec_sat` are valid.
- `ec_ready` in 1 — the inference stage consumes the output this cycle.
- `fuzzy_EC` out 5 — quantised EC index, 0..16 only.
- `ec_sat` out 1 — the index was clamped to 0 or 16.

## Operation

- Transfers: an input is accepted when `err_valid && err_ready`. An output is consumed when `ec_valid && ec_ready`.
- Advance enable: `adv = !ec_valid || ec_ready`. `err_ready = adv`. Both stages load only when `adv = 1`, so the whole pipe stalls as a unit.
- State machine (2 states):
  - PRIME: the reset state and the state after `clr`. An accepted sample is stored in `prev`, its diff is forced to 0, and the FSM goes to RUN.
  - RUN: an accepted sample gives diff = `err_in` − `prev`, then `prev` ← `err_in`. The FSM stays in RUN.
- The first sample after reset or `clr` always emits index 8 with `ec_sat = 0`. Every accepted sample produces exactly one output.
- Stage 1 (S1): registers `s1_valid` and `diff`. `diff` is DATA_W+1 bits signed and never overflows.
- Stage 2 (output register):
  - `q = diff >>> QUANT_SHIFT`, an arithmetic shift (floor toward −∞).
  - `idx = q + 8`, computed at full width.
  - If `idx < 0`, output 0 with `ec_sat = 1`. If `idx > 16`, output 16 with `ec_sat = 1`. Otherwise output `idx[4:0]` with `ec_sat = 0`.
- When `adv = 1`, S2 loads from S1 (valid and data), and S1 loads the new input or a bubble (`s1_valid = 0`).
- `clr`:
  - Forces PRIME and clears `s1_valid`. A sample accepted in the same cycle is dropped; `clr` has priority.
  - The S2 output register is not touched, so a pending output stays valid until it is consumed.
- `rst` has priority over `clr` and over every transfer.

## Timing

- Reset values: `ec_valid = 0`, `fuzzy_EC = 5'd8`, `ec_sat = 0`, `s1_valid = 0`, `prev = 0`, FSM = PRIME. `err_ready = 1` from the first cycle after reset.
- Latency: an input accepted at edge N appears with `ec_valid = 1` after edge N+1 (two registers). Throughput is 1 sample per clock when `ec_ready` is held high.
- Backpressure: while `ec_valid && !ec_ready`:
  - `err_ready = 0`.
  - `fuzzy_EC`, `ec_sat`, S1 and `prev` hold.
  - The outputs stay stable until they are consumed; no sample is lost or duplicated.
- Simultaneous consume and accept is allowed in the same cycle (full rate).
- `ec_valid` drops only after a consume cycle in which S1 held a bubble.
- Boundaries:
  - diff = `2^QUANT_SHIFT`·8 − 1 maps to 15.
  - diff = −`2^QUANT_SHIFT`·8 maps to 0 without saturation; one LSB more negative saturates.
  - Extreme inputs (−2^(DATA_W−1) vs 2^(DATA_W−1)−1) saturate cleanly.

## Test plan

1. Reset then prime (defaults): `rst` for 2 cycles; check `ec_valid = 0`, `fuzzy_EC = 8`. Send 100 → output 8, `ec_sat = 0`, 2 cycles after acceptance.
2. Quantisation: after 100, send 180 (diff 80 → q 5) → 13. Send 170 (diff −10 → q −1) → 7. Send 170 → 8.
3. Saturation: after 0, send 200 (q 12 → 20) → 16, `ec_sat = 1`. Then send −200 (diff −400 → q −25) → 0, `ec_sat = 1`. Then send −73 (diff 127 → q 7 → 15) → 15, `ec_sat = 0`.
4. Backpressure: stream 0, 16, 48, 48 with `ec_ready` low for 5 cycles after the first output. Check:
   - outputs are exactly 8, 9, 10, 8, in order, none dropped;
   - `err_ready = 0` while stalled;
   - the outputs are stable during the stall.
5. Full rate: continuous valid input with `ec_ready = 1`. Check one output per cycle after 2 cycles of latency, and `err_ready` constantly 1.
6. `clr` and mid-stream reset:
   - Assert `clr` with `err_valid` and 500 in the same cycle → the sample is dropped. The next sample 900 → 8 (re-primed).
   - Assert `rst` while `ec_valid = 1` → all state returns to its reset values next cycle, and the first new sample → 8.

Source files
------------

// File: rtl/fuzzify_ec_2.sv
// Error-change fuzzifier: EC = e(k) - e(k-1), scaled by 2^QUANT_SHIFT and
// quantised onto the 17-level universe 0..16 (8 = ZE), two-stage valid/ready pipe.
module fuzzify_ec_2 #(
    parameter int DATA_W      = 16,
    parameter int QUANT_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     err_valid,
    input  logic signed [DATA_W-1:0] err_in,
    output logic                     err_ready,
    output logic                     ec_valid,
    input  logic                     ec_ready,
    output logic [4:0]               fuzzy_EC,
    output logic                     ec_sat
);

    // state | meaning
    // PRIME | no previous sample held; next accepted sample emits ZE
    // RUN   | prev holds e(k-1); accepted samples produce a real difference
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic signed [DATA_W+1:0] IDX_ZE  = (DATA_W+2)'(8);
    localparam logic signed [DATA_W+1:0] IDX_MAX = (DATA_W+2)'(16);

    state_t                   state;
    state_t                   state_nxt;
    logic                     adv;
    logic                     accept;
    logic                     s1_valid;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   diff_nxt;
    logic signed [DATA_W-1:0] prev;
    logic signed [DATA_W:0]   q;
    logic signed [DATA_W+1:0] idx;
    logic [4:0]               idx_clamped;
    logic                     sat_nxt;

    // The whole pipe moves as one unit, so a single enable gates both stages.
    assign adv       = !ec_valid || ec_ready;
    assign err_ready = adv;
    assign accept    = err_valid && adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = PRIME;
        end else if (accept) begin
            state_nxt = RUN;
        end
    end

    // One extra bit keeps the difference of any two samples exact.
    always_comb begin
        diff_nxt = '0;
        if (state == RUN) begin
            diff_nxt = (DATA_W+1)'(err_in) - (DATA_W+1)'(prev);
        end
    end

    assign q   = diff >>> QUANT_SHIFT;
    assign idx = (DATA_W+2)'(q) + IDX_ZE;

    always_comb begin
        idx_clamped = idx[4:0];
        sat_nxt     = 1'b0;
        if (idx[DATA_W+1]) begin
            idx_clamped = 5'd0;
            sat_nxt     = 1'b1;
        end else if (idx > IDX_MAX) begin
            idx_clamped = 5'd16;
            sat_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            diff     <= '0;
            prev     <= '0;
            ec_valid <= 1'b0;
            fuzzy_EC <= 5'd8;
            ec_sat   <= 1'b0;
        end else begin
            if (adv) begin
                ec_valid <= s1_valid;
                if (s1_valid) begin
                    fuzzy_EC <= idx_clamped;
                    ec_sat   <= sat_nxt;
                end
            end
            // clr drops S1 and any sample offered with it, but leaves S2 alone.
            if (clr) begin
                s1_valid <= 1'b0;
            end else if (adv) begin
                s1_valid <= err_valid;
                if (err_valid) begin
                    diff <= diff_nxt;
                    prev <= err_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_fuzzify_ec_2.sv
// Scoreboard bench for fuzzify_ec_2: directed vectors, stalls, clr/rst
// and randomized traffic against an arithmetic reference model.
module tb_fuzzify_ec_2;

    localparam int DW = 16;
    localparam int QS = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic                 err_valid;
    logic signed [DW-1:0] err_in;
    logic                 err_ready;
    logic                 ec_valid;
    logic                 ec_ready;
    logic [4:0]           fuzzy_EC;
    logic                 ec_sat;

    fuzzify_ec_2 #(.DATA_W(DW), .QUANT_SHIFT(QS)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .err_valid(err_valid), .err_in(err_in), .err_ready(err_ready),
        .ec_valid(ec_valid), .ec_ready(ec_ready),
        .fuzzy_EC(fuzzy_EC), .ec_sat(ec_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_prev  = 0;
    bit   m_primed = 1'b0;
    bit   lat_check = 1'b0;
    bit   rand_rdy  = 1'b0;
    int   max_wait  = 0;
    bit   stall_prev = 1'b0;
    int   last_idx = 0;
    int   last_sat = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: floor(diff / quantum) + 8, clamped to 0..16.
    function automatic exp_t model(input int v);
        exp_t e;
        int   d;
        int   qv;
        int   quantum;
        quantum = 1 << QS;
        d  = m_primed ? (v - m_prev) : 0;
        qv = (d >= 0) ? (d / quantum) : -((-d + quantum - 1) / quantum);
        e.idx = qv + 8;
        e.sat = 0;
        if (e.idx < 0) begin
            e.idx = 0;
            e.sat = 1;
        end else if (e.idx > 16) begin
            e.idx = 16;
            e.sat = 1;
        end
        e.cyc = cyc;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus side of the scoreboard: every accepted sample pushes its expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_prev   = 0;
            m_primed = 1'b0;
        end else if (clr) begin
            m_primed = 1'b0;
        end else if (err_valid && err_ready) begin
            sb.push_back(model(int'(err_in)));
            m_prev   = int'(err_in);
            m_primed = 1'b1;
        end
    end

    // Monitor: handshake rule, stall stability and in-order output checking.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("err_ready_rule", int'(err_ready), int'(!ec_valid || ec_ready));
            if (stall_prev) begin
                chk("stall_valid", int'(ec_valid), 1);
                chk("stall_idx", int'(fuzzy_EC), last_idx);
                chk("stall_sat", int'(ec_sat), last_sat);
            end
            if (ec_valid && ec_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", int'(fuzzy_EC), -1);
                end else begin
                    e = sb.pop_front();
                    chk("fuzzy_EC", int'(fuzzy_EC), e.idx);
                    chk("ec_sat", int'(ec_sat), e.sat);
                    if (lat_check) chk("latency", cyc - e.cyc, 2);
                end
            end
            stall_prev = ec_valid && !ec_ready;
            last_idx   = int'(fuzzy_EC);
            last_sat   = int'(ec_sat);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) ec_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send(input int v);
        int w;
        err_in    = DW'(v);
        err_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!err_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!err_ready) chk("send_timeout", w, 0);
        if (w > max_wait) max_wait = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        err_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        err_valid = 1'b0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reprime();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_ec_valid"}, int'(ec_valid), 0);
        chk({tag, "_fuzzy_EC"}, int'(fuzzy_EC), 8);
        chk({tag, "_ec_sat"}, int'(ec_sat), 0);
        chk({tag, "_err_ready"}, int'(err_ready), 1);
    endtask

    initial begin
        int w;
        rst = 1'b1; clr = 1'b0; err_valid = 1'b0; err_in = '0; ec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");
        @(posedge clk);
        #1;

        // Prime, quantisation, saturation.
        lat_check = 1'b1;
        send(100); send(180); send(170); send(170);
        drain();
        reprime();
        send(0); send(200); send(-200); send(-73);
        drain();

        // Boundaries: +127 -> 15, -128 -> 0 unsaturated, -129 -> 0 saturated, extremes.
        reprime();
        send(0); send(127); send(-1); send(-130);
        drain();
        reprime();
        send(-32768); send(32767); send(-32768);
        drain();

        // Full rate: one accept per cycle, latency 2 enforced by the monitor.
        reprime();
        max_wait = 0;
        for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 600)) - 300);
        chk("full_rate_wait", max_wait, 0);
        drain();
        lat_check = 1'b0;

        // Backpressure: outputs 8, 9, 10, 8 with a 5-cycle stall.
        reprime();
        ec_ready = 1'b0;
        fork
            begin
                send(0); send(16); send(48); send(48);
                idle();
            end
            begin
                w = 0;
                @(negedge clk);
                while (!ec_valid && w < 20) begin
                    w++;
                    @(negedge clk);
                end
                chk("bp_first_output", int'(ec_valid), 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_err_ready_low", int'(err_ready), 0);
                end
                @(posedge clk);
                #1 ec_ready = 1'b1;
            end
        join
        drain();

        // clr with a sample in the same cycle drops it and re-primes.
        clr = 1'b1; err_valid = 1'b1; err_in = DW'(500);
        @(posedge clk);
        #1 clr = 1'b0; err_valid = 1'b0;
        repeat (3) idle();
        send(900);
        drain();

        // Mid-stream reset while an output is pending.
        ec_ready = 1'b0;
        send(5); send(77);
        idle();
        @(negedge clk);
        chk("pre_rst_valid", int'(ec_valid), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("midrst");
        ec_ready = 1'b1;
        @(posedge clk);
        #1;
        send(-300); send(-250);
        drain();

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else if ($urandom_range(0, 1) == 0) send(int'($signed(16'($urandom))));
            else send(int'($urandom_range(0, 800)) - 400);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 ec_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
